md_unit: RTL and testbench

Multiply/divide sequencer owning the HI/LO register pair. Sits in the E stage beside the ALU: it accepts the decoded `mdOp` of the E-stage instruction, runs mult/multu/div/divu as a fixed-latency busy window, commits results to HI/LO, and serves mthi/mtlo/mfhi/mflo. It exports `busy`/`start` and a stall request so the hazard logic can freeze any multiply/divide-class instruction in D while the unit is occupied.

---
 rtl/md_unit_pkg.sv | 35 +++
 rtl/md_unit_if.sv | 27 ++
 rtl/md_unit.sv | 129 ++++++++++++
 tb/tb_md_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Shared types for the multiply/divide unit: mdOp codes, FSM states, HI/LO payload.
package md_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [OP_W-1:0] {
    MD_NOT   = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } md_pair_t;

  // Operations that occupy the busy window.
  function automatic logic is_md_launch(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage to multiply/divide unit connection, including hazard-facing status.
interface md_unit_if;
  import md_unit_pkg::*;

  logic              en;
  md_op_e            md_op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              d_is_md;
  logic              start;
  logic              busy;
  logic              stall;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output en, md_op, src_a, src_b, d_is_md,
    input  start, busy, stall, hi, lo, rd_data
  );

  modport slave (
    input  en, md_op, src_a, src_b, d_is_md,
    output start, busy, stall, hi, lo, rd_data
  );

endinterface

// File: rtl/md_unit.sv
// Multiply/divide sequencer owning HI/LO: results computed at launch, committed
// after a fixed busy window; also serves mthi/mtlo/mfhi/mflo.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic    clk,
  input logic    reset,
  md_unit_if.slave bus
);

  md_state_e         state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] hi_q, hi_nxt, lo_q, lo_nxt;
  md_pair_t          pend, pend_nxt;
  logic              p_wr, p_wr_nxt;
  logic              busy_q, start_c;

  logic [2*DATA_W-1:0] prod_s, prod_u;
  logic [DATA_W-1:0]   a_mag, b_mag, b_safe_s, b_safe_u;
  logic [DATA_W-1:0]   q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic                b_zero;

  assign busy_q  = (state == ST_BUSY);
  assign start_c = bus.en & ~busy_q & is_md_launch(bus.md_op);

  assign bus.start   = start_c;
  assign bus.busy    = busy_q;
  assign bus.stall   = bus.d_is_md & (start_c | busy_q);
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.rd_data = (bus.md_op == MD_MFHI) ? hi_q :
                       (bus.md_op == MD_MFLO) ? lo_q : '0;

  // Datapath: products and sign-magnitude division, divisor forced nonzero to stay X-free.
  always_comb begin
    prod_s   = {{DATA_W{bus.src_a[DATA_W-1]}}, bus.src_a} *
               {{DATA_W{bus.src_b[DATA_W-1]}}, bus.src_b};
    prod_u   = {{DATA_W{1'b0}}, bus.src_a} * {{DATA_W{1'b0}}, bus.src_b};
    b_zero   = (bus.src_b == '0);
    a_mag    = bus.src_a[DATA_W-1] ? DATA_W'(~bus.src_a + 1'b1) : bus.src_a;
    b_mag    = bus.src_b[DATA_W-1] ? DATA_W'(~bus.src_b + 1'b1) : bus.src_b;
    b_safe_s = b_zero ? DATA_W'(1) : b_mag;
    b_safe_u = b_zero ? DATA_W'(1) : bus.src_b;
    q_mag    = a_mag / b_safe_s;
    r_mag    = a_mag % b_safe_s;
    q_s      = (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]) ? DATA_W'(~q_mag + 1'b1) : q_mag;
    r_s      = bus.src_a[DATA_W-1] ? DATA_W'(~r_mag + 1'b1) : r_mag;
    q_u      = bus.src_a / b_safe_u;
    r_u      = bus.src_a % b_safe_u;
  end

  // Next-state and register update logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hi_nxt    = hi_q;
    lo_nxt    = lo_q;
    pend_nxt  = pend;
    p_wr_nxt  = p_wr;

    case (state)
      ST_IDLE: begin
        if (start_c) begin
          state_nxt = ST_BUSY;
          p_wr_nxt  = 1'b1;
          case (bus.md_op)
            MD_MULT: begin
              pend_nxt = md_pair_t'(prod_s);
              cnt_nxt  = CNT_W'(MULT_CYCLES);
            end
            MD_MULTU: begin
              pend_nxt = md_pair_t'(prod_u);
              cnt_nxt  = CNT_W'(MULT_CYCLES);
            end
            MD_DIV: begin
              pend_nxt.hi = r_s;
              pend_nxt.lo = q_s;
              p_wr_nxt    = ~b_zero;
              cnt_nxt     = CNT_W'(DIV_CYCLES);
            end
            default: begin
              pend_nxt.hi = r_u;
              pend_nxt.lo = q_u;
              p_wr_nxt    = ~b_zero;
              cnt_nxt     = CNT_W'(DIV_CYCLES);
            end
          endcase
        end else if (bus.en) begin
          if (bus.md_op == MD_MTHI) hi_nxt = bus.src_a;
          if (bus.md_op == MD_MTLO) lo_nxt = bus.src_a;
        end
      end
      ST_BUSY: begin
        cnt_nxt = CNT_W'(cnt - 1'b1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = ST_IDLE;
          if (p_wr) begin
            hi_nxt = pend.hi;
            lo_nxt = pend.lo;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      pend  <= '0;
      p_wr  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
      pend  <= pend_nxt;
      p_wr  <= p_wr_nxt;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with hand-computed HI/LO results.
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  md_unit_if mif();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mif.en    = 1'b0;
    mif.md_op = MD_NOT;
    mif.src_a = '0;
    mif.src_b = '0;
  endtask

  // Launch an op in cycle T, check busy/stall T+1..T+n and results at T+n+1.
  task automatic run_op(input string tag, input md_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic dmd,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    mif.en = 1'b1; mif.md_op = op; mif.src_a = a; mif.src_b = b; mif.d_is_md = dmd;
    #1;
    chk({tag, "_start"}, 32'(mif.start), 32'd1);
    chk({tag, "_stall_T"}, 32'(mif.stall), 32'(dmd));
    for (int i = 1; i <= n; i++) begin
      tick();
      idle_inputs();
      #1;
      chk({tag, "_busy"}, 32'(mif.busy), 32'd1);
      chk({tag, "_stall"}, 32'(mif.stall), 32'(dmd));
    end
    tick();
    chk({tag, "_busy_end"}, 32'(mif.busy), 32'd0);
    chk({tag, "_stall_end"}, 32'(mif.stall), 32'd0);
    chk({tag, "_hi"}, mif.hi, exp_hi);
    chk({tag, "_lo"}, mif.lo, exp_lo);
    mif.d_is_md = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    mif.d_is_md = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(mif.busy), 32'd0);
    chk("rst_hi", mif.hi, 32'h0);
    chk("rst_lo", mif.lo, 32'h0);
    chk("rst_start", 32'(mif.start), 32'd0);
    chk("rst_rd", mif.rd_data, 32'h0);

    tick();
    run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 1'b0, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", MD_DIVU, 32'd7, 32'd2, 10, 1'b1, 32'h1, 32'h3);

    // MTHI then divide by zero: HI/LO must survive the full window.
    mif.en = 1'b1; mif.md_op = MD_MTHI; mif.src_a = 32'h1234;
    #1;
    chk("mthi_start", 32'(mif.start), 32'd0);
    tick();
    idle_inputs();
    #1;
    chk("mthi_hi", mif.hi, 32'h1234);
    run_op("divu0", MD_DIVU, 32'd5, 32'd0, 10, 1'b0, 32'h1234, 32'h3);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 32'h0, 32'h8000_0000);

    // MULT issued while busy is ignored and completion time is unchanged.
    mif.en = 1'b1; mif.md_op = MD_MULT; mif.src_a = 32'd3; mif.src_b = 32'd4;
    tick();
    idle_inputs();
    tick();
    mif.en = 1'b1; mif.md_op = MD_MULT; mif.src_a = 32'd5; mif.src_b = 32'd5;
    #1;
    chk("ign_start", 32'(mif.start), 32'd0);
    tick();
    idle_inputs();
    tick();
    tick();
    #1;
    chk("ign_busy_T5", 32'(mif.busy), 32'd1);
    tick();
    chk("ign_busy_T6", 32'(mif.busy), 32'd0);
    chk("ign_hi", mif.hi, 32'h0);
    chk("ign_lo", mif.lo, 32'd12);

    // Reset mid-flight discards the pending result.
    mif.en = 1'b1; mif.md_op = MD_MULT; mif.src_a = 32'd3; mif.src_b = 32'd4;
    tick();
    idle_inputs();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(mif.busy), 32'd0);
    chk("rst_mid_hi", mif.hi, 32'h0);
    chk("rst_mid_lo", mif.lo, 32'h0);
    for (int i = 0; i < 6; i++) tick();
    chk("rst_mid_lo_late", mif.lo, 32'h0);
    chk("rst_mid_busy_late", 32'(mif.busy), 32'd0);

    // MTLO gated by en, then reads.
    mif.en = 1'b0; mif.md_op = MD_MTLO; mif.src_a = 32'hABCD;
    tick();
    chk("mtlo_en0", mif.lo, 32'h0);
    mif.en = 1'b1;
    tick();
    idle_inputs();
    #1;
    chk("mtlo_en1", mif.lo, 32'hABCD);
    mif.md_op = MD_MFLO;
    #1;
    chk("mflo_rd", mif.rd_data, 32'hABCD);
    mif.md_op = MD_MFHI;
    #1;
    chk("mfhi_rd", mif.rd_data, 32'h0);
    mif.md_op = MD_NOT;
    #1;
    chk("notmd_rd", mif.rd_data, 32'h0);
    mif.d_is_md = 1'b1;
    #1;
    chk("idle_stall", 32'(mif.stall), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
